// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the instruction fetch stage:
//   - fetch_state_e    : fetch FSM state encoding (IDLE/REQ/WAIT/HOLD)
//   - NOP_INSTR        : canonical RISC-V NOP (addi x0, x0, 0)
//   - DEFAULT_RESET_PC : PC fetched first after reset unless overridden
// -----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // one settling cycle after reset release
        S_REQ  = 2'd1,  // request presented to instruction memory
        S_WAIT = 2'd2,  // request accepted, waiting for the response
        S_HOLD = 2'd3   // instruction presented to decode
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : riscv_pkg

// File: rtl/fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
//   Program counter register for the fetch stage. A redirect loads the
//   word-aligned target and takes priority over sequential advance (+4).
//   The increment wraps modulo 2^ADDR_W.
// Ports
//   clk              in   clock, rising edge
//   rst_n            in   asynchronous active-low reset (pc <= RESET_PC)
//   redirect_valid_i in   load redirect target this cycle
//   redirect_pc_i    in   redirect target; bits [1:0] are forced to zero
//   advance_i        in   step to the next sequential word
//   pc_o             out  current PC
// -----------------------------------------------------------------------------
module fetch_pc_reg #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i & ~ADDR_W'(3);
        end else if (advance_i) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so that
    // every flop samples the pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule : fetch_pc_reg

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction fetch stage feeding the ControlUnit. Issues one word fetch at
//   a time to instruction memory, captures the response and presents it to
//   decode until consumed. A redirect may arrive in any state; a response
//   that was already requested for the old PC is discarded via the drop flag.
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   imem_req_valid   out  fetch request valid
//   imem_req_ready   in   memory accepts the request this cycle
//   imem_addr        out  word address of the request (always the current PC)
//   imem_rsp_valid   in   response pulse; ignored outside WAIT
//   imem_rsp_data    in   fetched instruction word
//   redirect_valid   in   branch/jump taken, load redirect_pc
//   redirect_pc      in   redirect target (bits [1:0] ignored)
//   instr_valid      out  instr/instr_pc valid for decode
//   instr_ready      in   decode consumes instr this cycle
//   instr            out  instruction word
//   instr_pc         out  PC of instr
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc
);

    fetch_state_e      state_q, state_d;
    logic              drop_q, drop_d;
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0] pc;
    logic              pc_advance;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .advance_i        (pc_advance),
        .pc_o             (pc)
    );

    // NOTE: every signal written in this block gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d        = state_q;
        drop_d         = drop_q;
        instr_valid_d  = instr_valid_q;
        instr_d        = instr_q;
        instr_pc_d     = instr_pc_q;
        pc_advance     = 1'b0;
        imem_req_valid = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    // The accepted request is for the old PC; its response
                    // must not reach decode.
                    if (redirect_valid) begin
                        drop_d = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop_q || redirect_valid) begin
                        // The single outstanding response has now arrived,
                        // so nothing remains to be dropped.
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d       = imem_rsp_data;
                        instr_pc_d    = pc;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    // A simultaneous instr_ready still consumes the word, but
                    // the PC follows the redirect rather than pc+4.
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    state_d       = S_REQ;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    pc_advance    = 1'b1;
                    state_d       = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            drop_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= RESET_PC;
        end else begin
            state_q       <= state_d;
            drop_q        <= drop_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign imem_addr   = pc;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed cycle table, an asynchronous-reset sequence, and a randomized run
//   scored against a transaction-level model of the fetch stream.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row per clock: outputs expected during the cycle, inputs driven for it.
    typedef struct {
        logic        redir;
        logic [31:0] redir_pc;
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        ready;
        logic        e_req_valid;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic [31:0] rpc, input logic rr, input logic rv,
                       input logic [31:0] rdata, input logic ir, input logic e_rv,
                       input logic [31:0] e_a, input logic e_iv, input logic [31:0] e_i,
                       input logic [31:0] e_p);
        vec_t v;
        v.redir = rd; v.redir_pc = rpc; v.req_ready = rr; v.rsp_valid = rv;
        v.rsp_data = rdata; v.ready = ir; v.e_req_valid = e_rv; v.e_addr = e_a;
        v.e_valid = e_iv; v.e_instr = e_i; v.e_pc = e_p;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic e_rv, input logic [31:0] e_a,
                                 input logic e_iv, input logic [31:0] e_i, input logic [31:0] e_p);
        check({tag, " req_valid"},   32'(imem_req_valid), 32'(e_rv));
        check({tag, " addr"},        imem_addr,           e_a);
        check({tag, " instr_valid"}, 32'(instr_valid),    32'(e_iv));
        check({tag, " instr"},       instr,               e_i);
        check({tag, " instr_pc"},    instr_pc,            e_p);
    endtask

    // Memory contents as seen by the random run: a fixed function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    initial begin
        idle_inputs();
        rst_n = 1'b0;

        //    rd rpc           rr rv rdata         ir   rv addr          iv instr         pc
        // Reset, first fetch, backpressure, sequential 0x4 / 0x8
        add(0, 32'h0,         1, 0, 32'h0,        0,   0, 32'h0,        0, NOP,          32'h0);
        add(0, 32'h0,         1, 0, 32'h0,        0,   1, 32'h0,        0, NOP,          32'h0);
        add(0, 32'h0,         0, 1, 32'h00500093, 0,   0, 32'h0,        0, NOP,          32'h0);
        add(0, 32'h0,         0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h00500093, 32'h0);
        add(0, 32'h0,         0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h00500093, 32'h0);
        add(0, 32'h0,         0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h00500093, 32'h0);
        add(0, 32'h0,         0, 0, 32'h0,        1,   0, 32'h0,        1, 32'h00500093, 32'h0);
        add(0, 32'h0,         0, 0, 32'h0,        0,   1, 32'h4,        0, 32'h00500093, 32'h0);
        add(0, 32'h0,         1, 0, 32'h0,        0,   1, 32'h4,        0, 32'h00500093, 32'h0);
        add(0, 32'h0,         0, 1, 32'h00A00113, 0,   0, 32'h4,        0, 32'h00500093, 32'h0);
        add(0, 32'h0,         0, 0, 32'h0,        1,   0, 32'h4,        1, 32'h00A00113, 32'h4);
        add(0, 32'h0,         1, 0, 32'h0,        0,   1, 32'h8,        0, 32'h00A00113, 32'h4);
        add(0, 32'h0,         0, 1, 32'h00208193, 0,   0, 32'h8,        0, 32'h00A00113, 32'h4);
        add(0, 32'h0,         0, 0, 32'h0,        1,   0, 32'h8,        1, 32'h00208193, 32'h8);
        // Redirect in WAIT: stale response discarded, refetch from 0x100
        add(0, 32'h0,         1, 0, 32'h0,        0,   1, 32'hC,        0, 32'h00208193, 32'h8);
        add(1, 32'h100,       0, 0, 32'h0,        0,   0, 32'hC,        0, 32'h00208193, 32'h8);
        add(0, 32'h0,         0, 1, 32'hDEADBEEF, 0,   0, 32'h100,      0, 32'h00208193, 32'h8);
        add(0, 32'h0,         1, 0, 32'h0,        0,   1, 32'h100,      0, 32'h00208193, 32'h8);
        add(0, 32'h0,         0, 1, 32'h12345678, 0,   0, 32'h100,      0, 32'h00208193, 32'h8);
        // Redirect in HOLD with instr_ready: target 0x203 aligns to 0x200
        add(1, 32'h203,       0, 0, 32'h0,        1,   0, 32'h100,      1, 32'h12345678, 32'h100);
        add(1, 32'hFFFFFFFE,  0, 0, 32'h0,        0,   1, 32'h200,      0, NOP,          32'h100);
        // Wrap: 0xFFFFFFFC + 4 -> 0x0
        add(0, 32'h0,         1, 0, 32'h0,        0,   1, 32'hFFFFFFFC, 0, NOP,          32'h100);
        add(0, 32'h0,         0, 1, 32'h0000006F, 0,   0, 32'hFFFFFFFC, 0, NOP,          32'h100);
        add(0, 32'h0,         0, 0, 32'h0,        1,   0, 32'hFFFFFFFC, 1, 32'h0000006F, 32'hFFFFFFFC);
        // Redirect together with accept: request stands, its response is dropped
        add(1, 32'h40,        1, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0000006F, 32'hFFFFFFFC);
        add(0, 32'h0,         0, 1, 32'hBAD00000, 0,   0, 32'h40,       0, 32'h0000006F, 32'hFFFFFFFC);
        // Response outside WAIT is ignored
        add(0, 32'h0,         0, 1, 32'h0BADBAD0, 0,   1, 32'h40,       0, 32'h0000006F, 32'hFFFFFFFC);
        add(0, 32'h0,         1, 0, 32'h0,        0,   1, 32'h40,       0, 32'h0000006F, 32'hFFFFFFFC);
        // Redirect and response in the same WAIT cycle: response discarded
        add(1, 32'h80,        0, 1, 32'h11111111, 0,   0, 32'h40,       0, 32'h0000006F, 32'hFFFFFFFC);
        add(0, 32'h0,         1, 0, 32'h0,        0,   1, 32'h80,       0, 32'h0000006F, 32'hFFFFFFFC);
        add(0, 32'h0,         0, 1, 32'h22222222, 0,   0, 32'h80,       0, 32'h0000006F, 32'hFFFFFFFC);
        add(0, 32'h0,         0, 0, 32'h0,        0,   0, 32'h80,       1, 32'h22222222, 32'h80);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            check_outputs($sformatf("row%0d", i), vecs[i].e_req_valid, vecs[i].e_addr,
                          vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc);
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].redir_pc;
            imem_req_ready = vecs[i].req_ready;
            imem_rsp_valid = vecs[i].rsp_valid;
            imem_rsp_data  = vecs[i].rsp_data;
            instr_ready    = vecs[i].ready;
            @(negedge clk);
        end

        // Asynchronous reset while a request to 0x84 is outstanding.
        idle_inputs();
        instr_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("pre-reset req_valid", 32'(imem_req_valid), 32'h1);
        check("pre-reset addr", imem_addr, 32'h84);
        imem_req_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1 check_outputs("async reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFEF00D;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_outputs("post-reset idle", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check_outputs("post-reset req", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
        @(negedge clk);
        check_outputs("post-reset still req", 1'b1, 32'h0, 1'b0, NOP, 32'h0);

        // Randomized run against the fetch-stream model.
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic [31:0] exp_pc;        // PC of the next instruction decode must see
            logic        mem_busy;
            int          mem_delay;
            logic [31:0] mem_data;
            logic        exp_invalid, exp_nop;
            logic        prev_hold;
            logic [31:0] prev_instr, prev_pc;
            int          delivered;
            logic        rd, rr, ir;
            logic [31:0] tgt;

            exp_pc = 32'h0; mem_busy = 1'b0; mem_delay = 0; mem_data = 32'h0;
            exp_invalid = 1'b0; exp_nop = 1'b0; prev_hold = 1'b0;
            prev_instr = 32'h0; prev_pc = 32'h0; delivered = 0;

            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (exp_invalid) check("rand invalid after redirect", 32'(instr_valid), 32'h0);
                if (exp_nop)     check("rand nop after hold redirect", instr, NOP);
                if (prev_hold) begin
                    check("rand hold valid", 32'(instr_valid), 32'h1);
                    check("rand hold instr", instr, prev_instr);
                    check("rand hold pc", instr_pc, prev_pc);
                end
                if (imem_req_valid) begin
                    check("rand one outstanding", 32'(mem_busy), 32'h0);
                end

                rd  = ($urandom % 12) == 0;
                tgt = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 + ($urandom % 16))
                                          : ($urandom & 32'h0000_0FFF);
                rr  = ($urandom % 3) != 0;
                ir  = ($urandom % 2) != 0;

                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
                if (mem_busy) begin
                    if (mem_delay == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem_data;
                        mem_busy       = 1'b0;
                    end else begin
                        mem_delay--;
                    end
                end else if ($urandom % 8 == 0) begin
                    imem_rsp_valid = 1'b1;   // stray pulse with junk data
                end

                if (imem_req_valid && rr) begin
                    check("rand request addr", imem_addr, exp_pc);
                    mem_busy  = 1'b1;
                    mem_delay = $urandom % 3;
                    mem_data  = mem_word(imem_addr);
                end

                if (instr_valid && ir) begin
                    check("rand deliver pc", instr_pc, exp_pc);
                    check("rand deliver instr", instr, mem_word(instr_pc));
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                end

                exp_invalid = rd;
                exp_nop     = rd && instr_valid;
                prev_hold   = instr_valid && !ir && !rd;
                prev_instr  = instr;
                prev_pc     = instr_pc;
                if (rd) exp_pc = tgt & ~32'h3;

                redirect_valid = rd;
                redirect_pc    = tgt;
                imem_req_ready = rr;
                instr_ready    = ir;
                @(negedge clk);
            end
            check("rand delivered enough", 32'(delivered > 100), 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instr_fetch_unit
